// File: rtl/vc_dest_arbiter.sv
// vc_dest_arbiter: pops at most one VC0/VC1 head per cycle toward D0/D1, forwarding it registered.
// Define ARB_WRR_EN for weighted round-robin (W0/W1); the default build is strict VC0 priority.
//   cur | meaning (ARB_WRR_EN only)
//   0   | VC0 holds credit
//   1   | VC1 holds credit
module vc_dest_arbiter #(
  parameter int BW = 6,
  parameter int W0 = 2,
  parameter int W1 = 1
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          en,
  input  logic          vc0_empty,
  input  logic          vc1_empty,
  input  logic [BW-1:0] vc0_data,
  input  logic [BW-1:0] vc1_data,
  input  logic          d0_pause,
  input  logic          d1_pause,
  output logic          vc0_rd,
  output logic          vc1_rd,
  output logic          d0_wr,
  output logic          d1_wr,
  output logic [BW-1:0] data_out,
  output logic          idle_out
);

  if (W0 < 1 || W0 > 15 || W1 < 1 || W1 > 15) begin : g_bad_weight
    $error("vc_dest_arbiter: W0 and W1 must be in 1..15");
  end

  logic          dst0, dst1, e0, e1, g0, g1;
  logic          d0_wr_q, d0_wr_d, d1_wr_q, d1_wr_d;
  logic [BW-1:0] data_q, data_d;

  assign dst0 = vc0_data[BW-2];
  assign dst1 = vc1_data[BW-2];
  assign e0   = en & ~vc0_empty & ~(dst0 ? d1_pause : d0_pause);
  assign e1   = en & ~vc1_empty & ~(dst1 ? d1_pause : d0_pause);

`ifdef ARB_WRR_EN
  typedef enum logic {CUR_VC0 = 1'b0, CUR_VC1 = 1'b1} cur_t;
  localparam logic [3:0] W0_C = 4'(W0);
  localparam logic [3:0] W1_C = 4'(W1);

  cur_t       cur_q, cur_d;
  logic [3:0] cnt_q, cnt_d, w_cur;

  always_comb begin
    g0    = 1'b0;
    g1    = 1'b0;
    cur_d = cur_q;
    cnt_d = cnt_q;
    w_cur = (cur_q == CUR_VC1) ? W1_C : W0_C;
    if (e0 && e1) begin
      g0 = (cur_q == CUR_VC0);
      g1 = (cur_q == CUR_VC1);
    end else begin
      g0 = e0;
      g1 = e1;
    end
    // Pop strobes must stay quiet while reset is held, independent of the inputs.
    if (!reset_L) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
    // Only a grant to the credit holder consumes credit; the other VC's grant is free.
    if ((g0 && cur_q == CUR_VC0) || (g1 && cur_q == CUR_VC1)) begin
      if (cnt_q + 4'd1 == w_cur) begin
        cur_d = (cur_q == CUR_VC0) ? CUR_VC1 : CUR_VC0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cur_q <= CUR_VC0;
      cnt_q <= '0;
    end else begin
      cur_q <= cur_d;
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    g0 = reset_L & e0;
    g1 = reset_L & ~e0 & e1;
  end
`endif

  always_comb begin
    d0_wr_d = (g0 & ~dst0) | (g1 & ~dst1);
    d1_wr_d = (g0 & dst0) | (g1 & dst1);
    data_d  = data_q;
    if (g0) begin
      data_d = vc0_data;
    end else if (g1) begin
      data_d = vc1_data;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      d0_wr_q <= 1'b0;
      d1_wr_q <= 1'b0;
      data_q  <= '0;
    end else begin
      d0_wr_q <= d0_wr_d;
      d1_wr_q <= d1_wr_d;
      data_q  <= data_d;
    end
  end

  assign vc0_rd   = g0;
  assign vc1_rd   = g1;
  assign d0_wr    = d0_wr_q;
  assign d1_wr    = d1_wr_q;
  assign data_out = data_q;
  assign idle_out = vc0_empty & vc1_empty & ~d0_wr_q & ~d1_wr_q;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Self-checking bench for vc_dest_arbiter: vector table, hand sequences and a randomized reference model.
// Follows ARB_WRR_EN the same way as the design.
module tb_vc_dest_arbiter;
  localparam int BW = 6;
  localparam int W0 = 2;
  localparam int W1 = 1;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          en = 1'b0;
  logic          vc0_empty = 1'b1, vc1_empty = 1'b1;
  logic [BW-1:0] vc0_data = '0, vc1_data = '0;
  logic          d0_pause = 1'b0, d1_pause = 1'b0;
  logic          vc0_rd, vc1_rd, d0_wr, d1_wr, idle_out;
  logic [BW-1:0] data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_dest_arbiter #(.BW(BW), .W0(W0), .W1(W1)) dut (
    .clk(clk), .reset_L(reset_L), .en(en),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .d0_pause(d0_pause), .d1_pause(d1_pause),
    .vc0_rd(vc0_rd), .vc1_rd(vc1_rd),
    .d0_wr(d0_wr), .d1_wr(d1_wr),
    .data_out(data_out), .idle_out(idle_out)
  );

  typedef struct {
    logic       en;
    logic       e0n;
    logic       e1n;
    logic [5:0] d0;
    logic [5:0] d1;
    logic       p0;
    logic       p1;
    logic       rd0;
    logic       rd1;
    logic       idle;
    logic       w0;
    logic       w1;
    logic [5:0] data;
  } vec_t;

  vec_t vecs[10];

  // reference model state
  logic [BW-1:0] m_data;
  logic          m_w0, m_w1;
`ifdef ARB_WRR_EN
  int m_own;
  int m_left;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // called at posedge+1; leaves DUT reset with no writes pending, back at posedge+1
  task automatic do_reset();
    en = 1'b0; vc0_empty = 1'b1; vc1_empty = 1'b1; d0_pause = 1'b0; d1_pause = 1'b0;
    reset_L = 1'b0;
    #2;
    reset_L = 1'b1;
    @(posedge clk); #1;
    m_data = '0; m_w0 = 1'b0; m_w1 = 1'b0;
`ifdef ARB_WRR_EN
    m_own = 0; m_left = W0;
`endif
  endtask

  task automatic apply_check(input vec_t v, input string name);
    en = v.en; vc0_empty = v.e0n; vc1_empty = v.e1n; vc0_data = v.d0; vc1_data = v.d1;
    d0_pause = v.p0; d1_pause = v.p1;
    #3;
    chk({name, ".vc0_rd"}, 32'(vc0_rd), 32'(v.rd0));
    chk({name, ".vc1_rd"}, 32'(vc1_rd), 32'(v.rd1));
    chk({name, ".idle"}, 32'(idle_out), 32'(v.idle));
    @(posedge clk); #1;
    chk({name, ".d0_wr"}, 32'(d0_wr), 32'(v.w0));
    chk({name, ".d1_wr"}, 32'(d1_wr), 32'(v.w1));
    chk({name, ".data"}, 32'(data_out), 32'(v.data));
  endtask

  task automatic model_cycle(input int n);
    logic dst0, dst1, e0, e1, g0, g1, eidle;
    dst0 = vc0_data[BW-2];
    dst1 = vc1_data[BW-2];
    e0 = en && !vc0_empty && !(dst0 ? d1_pause : d0_pause);
    e1 = en && !vc1_empty && !(dst1 ? d1_pause : d0_pause);
`ifdef ARB_WRR_EN
    if (e0 && e1) begin g0 = (m_own == 0); g1 = (m_own == 1); end
    else begin g0 = e0; g1 = e1; end
`else
    g0 = e0;
    g1 = !e0 && e1;
`endif
    eidle = vc0_empty && vc1_empty && !m_w0 && !m_w1;
    #3;
    chk($sformatf("rnd%0d.vc0_rd", n), 32'(vc0_rd), 32'(g0));
    chk($sformatf("rnd%0d.vc1_rd", n), 32'(vc1_rd), 32'(g1));
    chk($sformatf("rnd%0d.idle", n), 32'(idle_out), 32'(eidle));
    @(posedge clk); #1;
    if (g0) m_data = vc0_data;
    else if (g1) m_data = vc1_data;
    m_w0 = (g0 && !dst0) || (g1 && !dst1);
    m_w1 = (g0 && dst0) || (g1 && dst1);
    chk($sformatf("rnd%0d.d0_wr", n), 32'(d0_wr), 32'(m_w0));
    chk($sformatf("rnd%0d.d1_wr", n), 32'(d1_wr), 32'(m_w1));
    chk($sformatf("rnd%0d.data", n), 32'(data_out), 32'(m_data));
`ifdef ARB_WRR_EN
    if ((g0 && m_own == 0) || (g1 && m_own == 1)) begin
      m_left--;
      if (m_left == 0) begin
        m_own  = 1 - m_own;
        m_left = (m_own == 1) ? W1 : W0;
      end
    end
`endif
  endtask

  initial begin
    //            en e0n e1n d0     d1     p0 p1 rd0 rd1 idle w0 w1 data
    vecs[0] = '{1'b1, 1'b0, 1'b1, 6'h11, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h11};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 6'h05, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h05};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 6'h05, 6'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h05};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h05};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 6'h07, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h07};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h07};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 6'h11, 6'h02, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h02};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 6'h05, 6'h0A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h02};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 6'h00, 6'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'h33};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 6'h1F, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h33};

    // reset state, with an eligible VC0 head present
    en = 1'b1; vc0_empty = 1'b0; vc0_data = 6'h05;
    #3;
    chk("rst.vc0_rd", 32'(vc0_rd), 32'd0);
    chk("rst.vc1_rd", 32'(vc1_rd), 32'd0);
    chk("rst.d0_wr", 32'(d0_wr), 32'd0);
    chk("rst.d1_wr", 32'(d1_wr), 32'd0);
    chk("rst.data", 32'(data_out), 32'd0);
    chk("rst.idle", 32'(idle_out), 32'd0);
    vc0_empty = 1'b1;
    #1;
    chk("rst.idle_empty", 32'(idle_out), 32'd1);
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 10; i++) apply_check(vecs[i], $sformatf("vec%0d", i));

    // pop order with both VCs backlogged toward D0
    begin
      logic exp_order[6];
      int i0, i1;
`ifdef ARB_WRR_EN
      exp_order = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
      exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      do_reset();
      i0 = 0; i1 = 0;
      for (int k = 0; k < 6; k++) begin
        logic [5:0] exp_word;
        en = 1'b1; vc0_empty = 1'b0; vc1_empty = 1'b0;
        vc0_data = 6'(1 + i0);
        vc1_data = 6'(8'h21 + i1);
        #3;
        chk($sformatf("order%0d.vc1_rd", k), 32'(vc1_rd), 32'(exp_order[k]));
        chk($sformatf("order%0d.vc0_rd", k), 32'(vc0_rd), 32'(!exp_order[k]));
        exp_word = exp_order[k] ? 6'(8'h21 + i1) : 6'(1 + i0);
        @(posedge clk); #1;
        chk($sformatf("order%0d.d0_wr", k), 32'(d0_wr), 32'd1);
        chk($sformatf("order%0d.data", k), 32'(data_out), 32'(exp_word));
        if (exp_order[k]) i1++; else i0++;
      end
    end

    // pause on VC0's destination lets VC1 through without moving credit
    begin
      vec_t v;
      do_reset();
      v = '{1'b1, 1'b0, 1'b0, 6'h11, 6'h02, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h02};
      apply_check(v, "pause_on");
      v = '{1'b1, 1'b0, 1'b0, 6'h11, 6'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h11};
      apply_check(v, "pause_off");
    end

    // asynchronous reset between edges with a write in flight
    begin
      vec_t v;
      do_reset();
      v = '{1'b1, 1'b0, 1'b1, 6'h03, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h03};
      apply_check(v, "pre_rst0");
      apply_check(v, "pre_rst1");
      vc1_empty = 1'b0; vc1_data = 6'h04;
      #1;
      reset_L = 1'b0;
      #1;
      chk("midrst.d0_wr", 32'(d0_wr), 32'd0);
      chk("midrst.d1_wr", 32'(d1_wr), 32'd0);
      chk("midrst.data", 32'(data_out), 32'd0);
      chk("midrst.vc0_rd", 32'(vc0_rd), 32'd0);
      chk("midrst.vc1_rd", 32'(vc1_rd), 32'd0);
      chk("midrst.idle", 32'(idle_out), 32'd0);
      #1;
      reset_L = 1'b1;
      #1;
      chk("postrst.vc0_rd", 32'(vc0_rd), 32'd1);
      chk("postrst.vc1_rd", 32'(vc1_rd), 32'd0);
      @(posedge clk); #1;
      chk("postrst.d0_wr", 32'(d0_wr), 32'd1);
      chk("postrst.data", 32'(data_out), 32'h03);
    end

    // randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      en        = ($urandom_range(0, 99) < 85);
      vc0_empty = ($urandom_range(0, 99) < 25);
      vc1_empty = ($urandom_range(0, 99) < 25);
      vc0_data  = 6'($urandom);
      vc1_data  = 6'($urandom);
      d0_pause  = ($urandom_range(0, 99) < 25);
      d1_pause  = ($urandom_range(0, 99) < 25);
      model_cycle(n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_dest_arbiter.md
# vc_dest_arbiter

Weighted round-robin scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the QoS path. Each cycle it pops at most one word from a VC whose head word's destination FIFO is not paused. It forwards that word, registered, to D0 or D1. It sits between the VC FIFO stage and the D FIFO stage and is enabled by the path's control FSM.

## Interface
Parameters:
- BW, 6: word width; bit BW-2 of a word selects destination (0 → D0, 1 → D1).
- W0, 2: VC0 weight, consecutive grants per round, range 1..15.
- W1, 1: VC1 weight, range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- en  in  1  arbitration enable from control FSM (active state).
- vc0_empty, vc1_empty  in  1  VC FIFO empty flags.
- vc0_data, vc1_data  in  BW  VC FIFO head words; first-word-fall-through, valid whenever not empty.
- d0_pause, d1_pause  in  1  destination almost-full, from D FIFOs.
- vc0_rd, vc1_rd  out  1  combinational pop strobes to VC FIFOs.
- d0_wr, d1_wr  out  1  registered push strobes to D FIFOs.
- data_out  out  BW  registered word to D FIFOs.
- idle_out  out  1  no pending work.

## Operation
- Destination of a head word: dst_i = vc_i_data[BW-2].
- Eligibility: e_i = en & ~vc_i_empty & ~(dst_i ? d1_pause : d0_pause).
- State: cur (1 bit, VC currently holding credit), cnt (4 bits, grants used by cur).
- Grant (combinational, at most one):
  - both eligible → grant cur;
  - one eligible → grant it;
  - none → no grant.
- vc_i_rd = grant_i. At most one of vc0_rd and vc1_rd is high in any cycle.
- Credit update on a grant to cur:
  - if cnt+1 == W_cur → cur ← ~cur, cnt ← 0;
  - else cnt ← cnt+1.
- Grant to the non-current VC (cur ineligible) is work-conserving and leaves cur and cnt unchanged.
- No grant leaves cur and cnt unchanged.
- Forwarding: the clock edge after a grant loads data_out with the granted head word and asserts d0_wr or d1_wr per dst for one cycle. With no grant, both writes are 0 and data_out holds its value.
- idle_out = vc0_empty & vc1_empty & ~d0_wr & ~d1_wr.
- en low: no grants; in-flight write still completes; cur and cnt are held.

## Timing
- Reset (asynchronous assert): cur=VC0, cnt=0, d0_wr=0, d1_wr=0, data_out=0.
  - vc0_rd and vc1_rd are 0 while reset_L=0.
  - idle_out follows its equation.
- Reset mid-operation: a pending write is dropped; the popped word is lost by design. The first grant after deassertion goes to VC0 if eligible.
- Latency: pop in cycle N → d*_wr and data_out valid in cycle N+1.
- Throughput: one word per cycle sustained.
- Pause is sampled in the grant cycle, so one write may land after pause rises. D FIFO almost-full thresholds must leave at least 1 free slot.
- Back-to-back grants to the same destination with pause rising: the write from the pre-pause grant completes; no further grant to that destination occurs.
- Both heads target the same paused destination: no grant; state holds.
- Weight wrap: cnt never exceeds W_cur-1. W=1 alternates on every grant.

## Configuration
- ARB_WRR_EN defined: weighted round-robin as above.
- ARB_WRR_EN undefined: strict priority.
  - VC0 is granted whenever e0; VC1 only when ~e0 & e1.
  - cur and cnt are not implemented; W0 and W1 are ignored.
- All other behaviour and timing is identical in both builds.

## Test plan
- WRR, W0=2, W1=1, both VCs continuously non-empty with D0-bound words 0x01..0x06 (VC0) and 0x21..0x26 (VC1 with bit4=0 cleared as needed), no pause → pop order VC0,VC0,VC1,VC0,VC0,VC1; each d0_wr one cycle after its pop, data_out matching.
- Destination steering: VC0 head 6'b01_0001 (dst 1) → d1_wr=1, d0_wr=0, data_out=6'b01_0001 next cycle; head 6'b00_0101 → d0_wr.
- Pause: d1_pause=1, VC0 head dst 1, VC1 head dst 0 → only VC1 popped, cur and cnt unchanged. Release pause → VC0 granted next cycle.
- en=0 with both VCs non-empty → vc*_rd=0, idle_out=0. en raised → grant in the same cycle.
- Async reset asserted mid-stream, between clock edges → d*_wr, data_out and vc*_rd go to 0 immediately. After release, first grant is VC0.
- ARB_WRR_EN undefined, both VCs non-empty for 6 cycles → six VC0 pops, zero VC1 pops. Empty VC0 → VC1 popped the same cycle.
